// File: rtl/axi_pkg.sv
// Shared AXI3 write-slave constants and FSM state type.
package axi_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED  = 2'b00;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] BURST_WRAP   = 2'b10;
  localparam logic [1:0] BURST_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wslv_state_t;

endpackage

// File: rtl/wslv_ram.sv
// Word-addressed RAM: one byte-enabled write port, one registered read port.
// A same-cycle read of the word being written returns the old contents.
module wslv_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [DW-1:0]   rdata_o
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Byte-lane write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Registered read, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_write_slave.sv
// AXI3 write-channel slave: one burst at a time into a local RAM, B response,
// registered device read port and a completion pulse.
// Build option: AXI_WSLV_WSTRB_EN enables per-byte WSTRB masking.
module axi_write_slave
  import axi_pkg::*;
#(
  parameter int unsigned buswidth = 32,
  parameter int unsigned MEM_AW   = 6
) (
  input  logic                  devclock,
  input  logic                  ARESETn,
  input  logic [3:0]            AWID,
  input  logic [31:0]           AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            WID,
  input  logic [buswidth-1:0]   WDATA,
  input  logic [buswidth/8-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [3:0]            BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [MEM_AW-1:0]     rd_addr,
  output logic [buswidth-1:0]   rd_data,
  output logic                  wr_done
);

  localparam int unsigned STRB_W  = buswidth / 8;
  localparam int unsigned BYTE_SH = $clog2(STRB_W);
  localparam int unsigned IDX_SH  = MEM_AW + BYTE_SH;

  wslv_state_t state_q, state_d;
  logic [3:0]  id_q, id_d, len_q, len_d, beat_q, beat_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d, bresp_q, bresp_d;
  logic        dec_q, dec_d, slv_q, slv_d;

  logic        aw_hs, w_hs, last_beat, cfg_bad, beat_dec, beat_slv, ram_we;
  logic [31:0] step, wrap_mask, addr_nxt;
  logic [STRB_W-1:0] ram_be;

  assign AWREADY = (state_q == IDLE) & ARESETn;
  assign WREADY  = (state_q == DATA);
  assign BVALID  = (state_q == RESP);
  assign BID     = id_q;
  assign BRESP   = bresp_q;
  assign wr_done = BVALID & BREADY & ARESETn;

  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign last_beat = (beat_q == len_q);

  // Burst-wide protocol errors fixed by the latched AW fields.
  assign cfg_bad = (size_q > 3'(BYTE_SH)) | (burst_q == BURST_RSVD) |
                   ((burst_q == BURST_WRAP) &
                    !((len_q == 4'd1) | (len_q == 4'd3) | (len_q == 4'd7) | (len_q == 4'd15)));
  // Per-beat errors; a beat raising either is not written.
  assign beat_dec = (addr_q >> IDX_SH) != 32'd0;
  assign beat_slv = cfg_bad | (WID != id_q) | (WLAST != last_beat);
  assign ram_we   = w_hs & ~beat_dec & ~beat_slv;

`ifdef AXI_WSLV_WSTRB_EN
  assign ram_be = WSTRB;
`else
  // Strobes ignored: every accepted beat writes the whole word.
  logic unused_wstrb;
  assign unused_wstrb = ^WSTRB;
  assign ram_be       = '1;
`endif

  // Next beat address for FIXED / INCR / WRAP (32-bit, no carry out).
  always_comb begin
    step      = 32'd1 << size_q;
    wrap_mask = ((32'(len_q) + 32'd1) << size_q) - 32'd1;
    addr_nxt  = addr_q;
    case (burst_q)
      BURST_INCR: addr_nxt = addr_q + step;
      BURST_WRAP: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:    addr_nxt = addr_q;
    endcase
  end

  // FSM next-state and burst context update.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    dec_d   = dec_q;
    slv_d   = slv_q;
    bresp_d = bresp_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          id_d    = AWID;
          addr_d  = AWADDR;
          len_d   = AWLEN;
          size_d  = AWSIZE;
          burst_d = AWBURST;
          beat_d  = 4'd0;
          dec_d   = 1'b0;
          slv_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          addr_d = addr_nxt;
          beat_d = beat_q + 4'd1;
          dec_d  = dec_q | beat_dec;
          slv_d  = slv_q | beat_slv;
          if (last_beat | WLAST) begin
            state_d = RESP;
            bresp_d = (dec_q | beat_dec) ? BRESP_DECERR :
                      (slv_q | beat_slv) ? BRESP_SLVERR : BRESP_OKAY;
          end
        end
      end
      RESP: begin
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and context registers; synchronous active-low reset.
  always_ff @(posedge devclock) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      dec_q   <= 1'b0;
      slv_q   <= 1'b0;
      bresp_q <= BRESP_OKAY;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      dec_q   <= dec_d;
      slv_q   <= slv_d;
      bresp_q <= bresp_d;
    end
  end

  wslv_ram #(
    .DW (buswidth),
    .AW (MEM_AW)
  ) u_ram (
    .clk_i   (devclock),
    .rst_ni  (ARESETn),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .waddr_i (addr_q[BYTE_SH +: MEM_AW]),
    .wdata_i (WDATA),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_axi_write_slave.sv
// Scoreboard bench for axi_write_slave: B responses and RAM contents are
// queued as bursts are driven and compared when the DUT produces them.
module tb_axi_write_slave;

  logic        devclock = 1'b0;
  logic        ARESETn;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_done;

  axi_write_slave #(.buswidth(32), .MEM_AW(6)) dut (
    .devclock(devclock), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_done(wr_done)
  );

  always #5 devclock = ~devclock;

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [5:0] idx; logic [31:0] data; } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push_r(input logic [5:0] idx, input logic [31:0] data);
    r_exp_t r;
    r.idx = idx; r.data = data;
    r_q.push_back(r);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    b_exp_t b;
    b.id = id; b.resp = resp;
    b_q.push_back(b);
  endtask

  // Drain RAM expectations through the registered read port.
  task automatic drain_ram;
    r_exp_t r;
    while (r_q.size() > 0) begin
      r = r_q.pop_front();
      @(negedge devclock); rd_addr = r.idx;
      @(posedge devclock);
      @(negedge devclock);
      checks++;
      if (rd_data !== r.data) begin
        errors++;
        $display("FAIL ram[%0d] got %h exp %h", r.idx, rd_data, r.data);
      end
    end
  endtask

  // One complete burst: AW, W beats (beat bad_beat carries a wrong WID), B with optional stall.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                           input int bad_beat, input logic [3:0] strb, input int stall);
    int n;
    b_exp_t e;
    @(negedge devclock);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin @(negedge devclock); n++; end
    if (n >= 50) begin
      checks++; errors++; AWVALID = 1'b0;
      $display("FAIL aw_timeout got AWREADY=%b exp 1", AWREADY);
      return;
    end
    @(posedge devclock); #1 AWVALID = 1'b0;
    @(negedge devclock);
    checks++;
    if (WREADY !== 1'b1) begin errors++; $display("FAIL wready_latency got %b exp 1", WREADY); end
    for (int k = 0; k <= int'(len); k++) begin
      WID = (k == bad_beat) ? id + 4'd1 : id;
      WDATA = d0 + 32'(k); WSTRB = strb; WLAST = (k == int'(len)); WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin @(negedge devclock); n++; end
      if (n >= 50) begin
        checks++; errors++; WVALID = 1'b0;
        $display("FAIL w_timeout beat %0d got WREADY=%b exp 1", k, WREADY);
        return;
      end
      @(posedge devclock); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge devclock);
    checks++;
    if (BVALID !== 1'b1) begin errors++; $display("FAIL bvalid_latency got %b exp 1", BVALID); end
    if (b_q.size() == 0) begin
      checks++; errors++; $display("FAIL b_queue_empty got 0 entries exp 1");
      return;
    end
    e = b_q[0];
    for (int s = 0; s < stall; s++) begin
      checks++;
      if (BVALID !== 1'b1 || BID !== e.id || BRESP !== e.resp || AWREADY !== 1'b0) begin
        errors++;
        $display("FAIL b_stall cyc %0d got V=%b ID=%h R=%b AWR=%b exp V=1 ID=%h R=%b AWR=0",
                 s, BVALID, BID, BRESP, AWREADY, e.id, e.resp);
      end
      @(negedge devclock);
    end
    BREADY = 1'b1; #1;
    e = b_q.pop_front();
    checks++;
    if (BVALID !== 1'b1 || BID !== e.id || BRESP !== e.resp || wr_done !== 1'b1) begin
      errors++;
      $display("FAIL b_resp got V=%b ID=%h R=%b done=%b exp V=1 ID=%h R=%b done=1",
               BVALID, BID, BRESP, wr_done, e.id, e.resp);
    end
    @(posedge devclock); #1 BREADY = 1'b0;
    @(negedge devclock);
    checks++;
    if (wr_done !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      errors++;
      $display("FAIL b_after got done=%b V=%b AWR=%b exp 0 0 1", wr_done, BVALID, AWREADY);
    end
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    repeat (3) @(posedge devclock);
    @(negedge devclock);
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || wr_done !== 1'b0 ||
        BID !== 4'h0 || BRESP !== 2'b00 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got AWR=%b WR=%b BV=%b done=%b BID=%h BR=%b rd=%h exp all 0",
               AWREADY, WREADY, BVALID, wr_done, BID, BRESP, rd_data);
    end
    ARESETn = 1'b1; #1;
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL reset_release got AWREADY=%b exp 1", AWREADY); end
  endtask

  task automatic test_incr;
    push_b(4'd5, 2'b00);
    for (int k = 0; k < 4; k++) push_r(6'(4 + k), 32'hA000_0000 + 32'(k));
    run_burst(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 32'hA000_0000, -1, 4'hF, 0);
    drain_ram();
  endtask

  task automatic test_wrap;
    push_b(4'd6, 2'b00);
    push_r(6'd14, 32'hB000_0000); push_r(6'd15, 32'hB000_0001);
    push_r(6'd12, 32'hB000_0002); push_r(6'd13, 32'hB000_0003);
    run_burst(4'd6, 32'h38, 4'd3, 3'd2, 2'b10, 32'hB000_0000, -1, 4'hF, 0);
    drain_ram();
  endtask

  task automatic test_decerr;
    push_b(4'd1, 2'b00);
    run_burst(4'd1, 32'h0, 4'd0, 3'd2, 2'b01, 32'h0BAD_F00D, -1, 4'hF, 0);
    push_b(4'd7, 2'b11);
    run_burst(4'd7, 32'h100, 4'd0, 3'd2, 2'b01, 32'hFFFF_FFFF, -1, 4'hF, 0);
    push_r(6'd0, 32'h0BAD_F00D);
    drain_ram();
  endtask

  task automatic test_slverr;
    push_b(4'd2, 2'b00);
    run_burst(4'd2, 32'h40, 4'd1, 3'd2, 2'b01, 32'hC000_0000, -1, 4'hF, 0);
    push_b(4'd2, 2'b10);
    run_burst(4'd2, 32'h40, 4'd1, 3'd2, 2'b01, 32'hD000_0000, 1, 4'hF, 0);
    push_b(4'd4, 2'b10);
    run_burst(4'd4, 32'h40, 4'd2, 3'd2, 2'b10, 32'hE000_0000, -1, 4'hF, 0);
    push_b(4'd4, 2'b10);
    run_burst(4'd4, 32'h40, 4'd0, 3'd3, 2'b01, 32'hE100_0000, -1, 4'hF, 0);
    push_r(6'd16, 32'hD000_0000); push_r(6'd17, 32'hC000_0001);
    drain_ram();
  endtask

  task automatic test_bready_stall;
    push_b(4'd9, 2'b00);
    push_r(6'd8, 32'h9000_0000); push_r(6'd9, 32'h9000_0001);
    run_burst(4'd9, 32'h20, 4'd1, 3'd2, 2'b01, 32'h9000_0000, -1, 4'hF, 5);
    drain_ram();
  endtask

  task automatic test_wstrb;
    push_b(4'd3, 2'b00);
    run_burst(4'd3, 32'h0C, 4'd0, 3'd2, 2'b01, 32'h1111_1111, -1, 4'hF, 0);
    push_b(4'd3, 2'b00);
    run_burst(4'd3, 32'h0C, 4'd0, 3'd2, 2'b01, 32'hDEAD_BEEF, -1, 4'b0011, 0);
`ifdef AXI_WSLV_WSTRB_EN
    push_r(6'd3, 32'h1111_BEEF);
`else
    push_r(6'd3, 32'hDEAD_BEEF);
`endif
    drain_ram();
  endtask

  task automatic test_reset_mid_burst;
    @(negedge devclock);
    AWID = 4'd1; AWADDR = 32'h80; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL mid_aw got AWREADY=%b exp 1", AWREADY); end
    @(posedge devclock); #1 AWVALID = 1'b0;
    WID = 4'd1; WDATA = 32'h5A5A_0001; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    @(posedge devclock); #1 WVALID = 1'b0;
    @(negedge devclock); ARESETn = 1'b0;
    @(posedge devclock);
    @(negedge devclock);
    checks++;
    if (AWREADY !== 1'b0 || WREADY !== 1'b0 || BVALID !== 1'b0 || wr_done !== 1'b0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset got AWR=%b WR=%b BV=%b done=%b rd=%h exp 0 0 0 0 0",
               AWREADY, WREADY, BVALID, wr_done, rd_data);
    end
    ARESETn = 1'b1; #1;
    checks++;
    if (AWREADY !== 1'b1) begin errors++; $display("FAIL mid_release got AWREADY=%b exp 1", AWREADY); end
    repeat (3) begin
      @(negedge devclock);
      checks++;
      if (BVALID !== 1'b0) begin errors++; $display("FAIL mid_no_b got BVALID=%b exp 0", BVALID); end
    end
    push_r(6'd32, 32'h5A5A_0001);
    drain_ram();
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; rd_addr = '0;
    test_reset();
    test_incr();
    test_wrap();
    test_decerr();
    test_slverr();
    test_bready_stall();
    test_wstrb();
    test_reset_mid_burst();
    checks++;
    if (b_q.size() != 0) begin errors++; $display("FAIL b_leftover got %0d exp 0", b_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
